uart_transmitter: RTL and testbench

- Serial transmitter that drives a byte stream onto the CPU's FPGA_SERIAL_RX line, using 8N1 framing at BAUD_RATE.
- It is the far end of the CPU's UART receive path. It is used as the host-side stimulus driver and loopback partner in system benches and board harnesses.
- Bytes are accepted over a ready/valid interface into an internal FIFO. They are serialized LSB-first with exact per-bit timing.

---
 rtl/uart_transmitter_if.sv | 19 +
 rtl/uart_transmitter.sv | 130 +++++++++++++
 tb/tb_uart_transmitter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer holds data_in and data_in_valid; the transmitter returns data_in_ready.
interface uart_transmitter_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter fed by a byte FIFO; each bit is held CLOCK_FREQ/BAUD_RATE cycles.
// Frames are sent back to back while the FIFO has data, with no idle cycle between them.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  uart_transmitter_if.slave              host,
  output logic                           serial_out,
  output logic                           busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W   = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [2:0]         bit_idx, bit_idx_next;
  logic [7:0]         shift, shift_next;
  logic [COUNT_W-1:0] count_next;
  logic               serial_next;
  logic               busy_next;
  logic               push;
  logic               pop;
  logic               bit_done;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Ready uses the registered count, so a full FIFO refuses a push even when a pop happens alongside.
  assign host.data_in_ready = rst & (fifo_count != COUNT_FULL);
  assign push     = host.data_in_valid & host.data_in_ready;
  assign bit_done = (cnt == CNT_LAST);

  always_comb begin
    state_next   = state;
    cnt_next     = cnt + CNT_W'(1);
    bit_idx_next = bit_idx;
    shift_next   = shift;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (fifo_count != '0) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_next     = '0;
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_next = '0;
          if (fifo_count != '0) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    count_next = fifo_count + COUNT_W'(push) - COUNT_W'(pop);

    // The line level is registered from the next state so it changes on the same edge as the FSM.
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = shift_next[bit_idx_next];
      default: serial_next = 1'b1;
    endcase

    busy_next = (state_next != IDLE) | (count_next != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_idx_next;
      fifo_count <= count_next;
      serial_out <= serial_next;
      busy       <= busy_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Byte storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    shift <= shift_next;
    if (push) mem[wr_ptr] <= host.data_in;
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with a reduced baud divisor so a full 256-byte loopback fits.
// A free-running line decoder collects received bytes for order and framing checks.
module tb_uart_transmitter;

  localparam int CLOCK_FREQ = 1_000_000;
  localparam int BAUD_RATE  = 60_000;
  localparam int FIFO_DEPTH = 8;
  // 1_000_000 / 60_000 = 16.67, truncated to 16 cycles per bit
  localparam int S = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_out;
  logic       busy;
  logic [3:0] fifo_count;

  uart_transmitter_if host ();

  uart_transmitter #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host),
    .serial_out(serial_out),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] rx_q[$];
  int         frame_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts at the first cycle of the start bit and ends on the edge after the stop bit.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic expv;
    int   errs;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      expv = 1'b0;
      else if (k == 9) expv = 1'b1;
      else             expv = b[k-1];
      errs = 0;
      for (int c = 0; c < S; c++) begin
        if (serial_out !== expv) errs++;
        tick();
      end
      check($sformatf("%s bit%0d", tag, k), errs, 0);
    end
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    check(tag, (n < limit), 1);
  endtask

  initial begin : line_monitor
    logic [7:0] b;
    logic       ok;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && serial_out === 1'b0) begin
        ok = 1'b1;
        b  = '0;
        repeat (S/2) @(negedge clk);
        if (serial_out !== 1'b0) ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (S) @(negedge clk);
          b[k] = serial_out;
        end
        repeat (S) @(negedge clk);
        if (serial_out !== 1'b1) ok = 1'b0;
        if (ok) rx_q.push_back(b);
        else    frame_err++;
      end
    end
  end

  initial begin : watchdog
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int         n;
    int         errs;
    int         timeouts;
    logic [7:0] exp_b;

    // Reset with a push attempt held high
    host.data_in       = 8'h3C;
    host.data_in_valid = 1'b1;
    rst = 1'b0;
    repeat (3) tick();
    check("rst serial_out", serial_out, 1);
    check("rst ready", host.data_in_ready, 0);
    check("rst busy", busy, 0);
    check("rst fifo_count", fifo_count, 0);
    rst = 1'b1;
    host.data_in_valid = 1'b0;
    tick();
    check("post-rst ready", host.data_in_ready, 1);
    check("post-rst fifo_count", fifo_count, 0);
    errs = 0;
    for (int c = 0; c < 2*S; c++) begin
      if (serial_out !== 1'b1 || busy !== 1'b0) errs++;
      tick();
    end
    check("post-rst quiet line", errs, 0);

    // Single byte 0xA5
    rx_q.delete();
    host.data_in       = 8'hA5;
    host.data_in_valid = 1'b1;
    tick();
    host.data_in_valid = 1'b0;
    check("a5 count after push", fifo_count, 1);
    check("a5 line before start", serial_out, 1);
    check("a5 busy after push", busy, 1);
    tick();
    check_frame(8'hA5, "a5");
    check("a5 busy after frame", busy, 0);
    check("a5 idle line", serial_out, 1);
    check("a5 count after frame", fifo_count, 0);

    // Back-to-back 0x00 then 0xFF
    host.data_in       = 8'h00;
    host.data_in_valid = 1'b1;
    tick();
    host.data_in = 8'hFF;
    tick();
    host.data_in_valid = 1'b0;
    check("b2b count during first", fifo_count, 1);
    check_frame(8'h00, "b2b 00");
    check("b2b count at second start", fifo_count, 0);
    check("b2b busy no gap", busy, 1);
    check_frame(8'hFF, "b2b ff");
    check("b2b busy end", busy, 0);
    check("rx count after a5/b2b", rx_q.size(), 3);
    check("rx a5", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'hA5);
    check("rx 00", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h00);
    check("rx ff", (rx_q.size() > 2) ? rx_q[2] : 8'hxx, 8'hFF);

    // Overflow: valid held high for ten bytes starting from an idle FIFO
    rx_q.delete();
    host.data_in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      host.data_in = 8'(8'h10 + i);
      tick();
    end
    check("ovf count full", fifo_count, 8);
    check("ovf ready low", host.data_in_ready, 0);
    host.data_in = 8'h19;
    n = 0;
    while (host.data_in_ready !== 1'b1 && n < 20*S) begin
      tick();
      n++;
    end
    check("ovf ready wait cycles", n, 10*S - 7);
    tick();
    host.data_in_valid = 1'b0;
    check("ovf count refilled", fifo_count, 8);
    wait_idle(120*S, "ovf drain timeout");
    check("ovf rx count", rx_q.size(), 10);
    for (int i = 0; i < 10; i++) begin
      exp_b = 8'(8'h10 + i);
      check($sformatf("ovf rx[%0d]", i), (rx_q.size() > i) ? rx_q[i] : 8'hxx, exp_b);
    end

    // Reset during bit 3 of 0x55 with two bytes queued
    host.data_in_valid = 1'b1;
    host.data_in = 8'h55;
    tick();
    host.data_in = 8'h11;
    tick();
    host.data_in = 8'h22;
    tick();
    host.data_in_valid = 1'b0;
    repeat (71) tick();
    check("midrst count before", fifo_count, 2);
    check("midrst bit3 level", serial_out, 0);
    rst = 1'b0;
    tick();
    check("midrst serial_out", serial_out, 1);
    check("midrst fifo_count", fifo_count, 0);
    check("midrst busy", busy, 0);
    check("midrst ready", host.data_in_ready, 0);
    rst = 1'b1;
    errs = 0;
    for (int c = 0; c < 12*S; c++) begin
      if (serial_out !== 1'b1 || busy !== 1'b0) errs++;
      tick();
    end
    check("midrst no frame after release", errs, 0);
    rx_q.delete();
    frame_err = 0;

    // Loopback 0x00..0xFF through the line decoder
    timeouts = 0;
    for (int i = 0; i < 256; i++) begin
      host.data_in       = 8'(i);
      host.data_in_valid = 1'b1;
      n = 0;
      while (host.data_in_ready !== 1'b1 && n < 20*S) begin
        tick();
        n++;
      end
      if (n >= 20*S) timeouts++;
      tick();
    end
    host.data_in_valid = 1'b0;
    check("loop push timeouts", timeouts, 0);
    wait_idle(20*S*FIFO_DEPTH, "loop drain timeout");
    check("loop rx count", rx_q.size(), 256);
    check("loop framing errors", frame_err, 0);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (rx_q.size() <= i || rx_q[i] !== 8'(i)) errs++;
    end
    check("loop data order", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
